stream_req_arbiter: RTL and testbench

//  Shares the single filter/input stream port among NUM_PE PE controllers. Each PE raises

---
 rtl/stream_req_arbiter.sv | 174 +++++++++++++++++
 tb/tb_stream_req_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_req_arbiter.sv
// Round-robin arbiter that shares one filter/input stream port among NUM_PE PE controllers.
// Grants one transfer at a time, pulses start/finish, and aborts stalled transfers via a watchdog.
module stream_req_arbiter #(
    parameter int NUM_PE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PE-1:0]         req_filter_valid,
    input  logic [NUM_PE-1:0]         req_input_valid,
    input  logic                      stream_complete,
    output logic [NUM_PE-1:0]         grant_onehot,
    output logic [$clog2(NUM_PE)-1:0] stream_pe_id,
    output logic                      stream_is_input,
    output logic                      stream_start,
    output logic [NUM_PE-1:0]         stream_filter_finish,
    output logic [NUM_PE-1:0]         stream_input_finish,
    output logic                      err_timeout,
    output logic                      err_spurious
);

    localparam int IW = $clog2(NUM_PE);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_PE-1:0]   grant_q, grant_d;
    logic [IW-1:0]       pe_id_q, pe_id_d;
    logic                is_input_q, is_input_d;
    logic                start_q, start_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_PE-1:0]   served_in_q, served_in_d;
    logic [NUM_PE-1:0]   served_f_q, served_f_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_spurious_q, err_spurious_d;

    logic [NUM_PE-1:0]   elig_in, elig_f;
    logic                win_found;
    logic [IW-1:0]       win_idx;
    logic [IW-1:0]       rr_next;
    logic                timeout_hit;

    assign elig_in = req_input_valid & ~served_in_q;
    assign elig_f  = req_filter_valid & ~served_f_q;

    // Scan from rr_ptr upward with wrap; first PE with any eligible request wins.
    always_comb begin
        logic [IW:0] idx_wide;
        logic [IW-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx_wide  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            idx_wide = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (idx_wide >= (IW+1)'(NUM_PE)) begin
                idx_wide = idx_wide - (IW+1)'(NUM_PE);
            end
            idx = idx_wide[IW-1:0];
            if (!win_found && (elig_in[idx] || elig_f[idx])) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign rr_next     = (pe_id_q == IW'(NUM_PE - 1)) ? '0 : pe_id_q + IW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        pe_id_d        = pe_id_q;
        is_input_d     = is_input_q;
        start_d        = 1'b0;
        rr_ptr_d       = rr_ptr_q;
        timer_d        = timer_q;
        err_timeout_d  = err_timeout_q;
        err_spurious_d = err_spurious_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d    = S_BUSY;
                    grant_d    = NUM_PE'(1) << win_idx;
                    pe_id_d    = win_idx;
                    is_input_d = elig_in[win_idx];
                    start_d    = 1'b1;
                    timer_d    = '0;
                end
            end
            S_BUSY: begin
                timer_d = timer_q + TW'(1);
                if (stream_complete) begin
                    state_d  = S_DONE;
                    rr_ptr_d = rr_next;
                end else if (timeout_hit) begin
                    state_d       = S_IDLE;
                    grant_d       = '0;
                    pe_id_d       = '0;
                    is_input_d    = 1'b0;
                    rr_ptr_d      = rr_next;
                    err_timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                pe_id_d    = '0;
                is_input_d = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                pe_id_d    = '0;
                is_input_d = 1'b0;
            end
        endcase

        if (stream_complete && (state_q != S_BUSY)) begin
            err_spurious_d = 1'b1;
        end
    end

    // A served bit only matters while the request is still held, so a low request always clears it.
    always_comb begin
        served_in_d = (served_in_q | stream_input_finish) & req_input_valid;
        served_f_d  = (served_f_q | stream_filter_finish) & req_filter_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            grant_q        <= '0;
            pe_id_q        <= '0;
            is_input_q     <= 1'b0;
            start_q        <= 1'b0;
            rr_ptr_q       <= '0;
            served_in_q    <= '0;
            served_f_q     <= '0;
            timer_q        <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            pe_id_q        <= pe_id_d;
            is_input_q     <= is_input_d;
            start_q        <= start_d;
            rr_ptr_q       <= rr_ptr_d;
            served_in_q    <= served_in_d;
            served_f_q     <= served_f_d;
            timer_q        <= timer_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign grant_onehot         = grant_q;
    assign stream_pe_id         = pe_id_q;
    assign stream_is_input      = is_input_q;
    assign stream_start         = start_q;
    assign stream_input_finish  = ((state_q == S_DONE) && is_input_q)  ? grant_q : '0;
    assign stream_filter_finish = ((state_q == S_DONE) && !is_input_q) ? grant_q : '0;
    assign err_timeout          = err_timeout_q;
    assign err_spurious         = err_spurious_q;

endmodule

// File: tb/tb_stream_req_arbiter.sv
// Directed bench for stream_req_arbiter (NUM_PE=4, TIMEOUT=8): inputs change 1 time unit
// after the rising edge and outputs are checked at that same point.
module tb_stream_req_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_filter_valid = '0;
    logic [3:0] req_input_valid  = '0;
    logic       stream_complete  = 1'b0;
    logic [3:0] grant_onehot;
    logic [1:0] stream_pe_id;
    logic       stream_is_input;
    logic       stream_start;
    logic [3:0] stream_filter_finish;
    logic [3:0] stream_input_finish;
    logic       err_timeout;
    logic       err_spurious;

    int errors = 0;
    int checks = 0;

    stream_req_arbiter #(.NUM_PE(4), .TIMEOUT(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_filter_valid     (req_filter_valid),
        .req_input_valid      (req_input_valid),
        .stream_complete      (stream_complete),
        .grant_onehot         (grant_onehot),
        .stream_pe_id         (stream_pe_id),
        .stream_is_input      (stream_is_input),
        .stream_start         (stream_start),
        .stream_filter_finish (stream_filter_finish),
        .stream_input_finish  (stream_input_finish),
        .err_timeout          (err_timeout),
        .err_spurious         (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_filter_valid = '0;
        req_input_valid  = '0;
        stream_complete  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Advances until stream_start is seen, giving up after a fixed cycle budget.
    task automatic wait_start(output bit found);
        int n;
        found = 1'b0;
        n = 0;
        while (!found && n < 12) begin
            if (stream_start) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (grant_onehot !== 4'b0) begin errors++; $display("FAIL reset_grant got=%b want=0000", grant_onehot); end
        checks++; if (stream_pe_id !== 2'd0 || stream_is_input !== 1'b0 || stream_start !== 1'b0) begin
            errors++; $display("FAIL reset_ctl got id=%0d in=%b start=%b want 0/0/0", stream_pe_id, stream_is_input, stream_start); end
        checks++; if (stream_filter_finish !== 4'b0 || stream_input_finish !== 4'b0) begin
            errors++; $display("FAIL reset_finish got f=%b i=%b want 0000", stream_filter_finish, stream_input_finish); end
        checks++; if (err_timeout !== 1'b0 || err_spurious !== 1'b0) begin
            errors++; $display("FAIL reset_err got to=%b sp=%b want 0/0", err_timeout, err_spurious); end
    endtask

    task automatic test_single();
        req_input_valid = 4'b0100;
        tick();
        checks++; if (grant_onehot !== 4'b0100 || stream_pe_id !== 2'd2 || stream_is_input !== 1'b1 || stream_start !== 1'b1) begin
            errors++; $display("FAIL single_grant got g=%b id=%0d in=%b st=%b want 0100/2/1/1", grant_onehot, stream_pe_id, stream_is_input, stream_start); end
        tick();
        checks++; if (stream_start !== 1'b0 || grant_onehot !== 4'b0100) begin
            errors++; $display("FAIL single_busy got st=%b g=%b want 0/0100", stream_start, grant_onehot); end
        repeat (3) tick();
        stream_complete = 1'b1;
        tick();
        stream_complete = 1'b0;
        checks++; if (stream_input_finish !== 4'b0100 || stream_filter_finish !== 4'b0000 || grant_onehot !== 4'b0100) begin
            errors++; $display("FAIL single_finish got i=%b f=%b g=%b want 0100/0000/0100", stream_input_finish, stream_filter_finish, grant_onehot); end
        req_input_valid = 4'b0000;
        tick();
        checks++; if (grant_onehot !== 4'b0 || stream_input_finish !== 4'b0) begin
            errors++; $display("FAIL single_idle got g=%b i=%b want 0000/0000", grant_onehot, stream_input_finish); end
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        bit found;
        logic [3:0] oh;
        reset_dut();
        req_filter_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            oh = 4'b0001 << exp_seq[n];
            wait_start(found);
            checks++; if (!found || grant_onehot !== oh || stream_pe_id !== 2'(exp_seq[n]) || stream_is_input !== 1'b0) begin
                errors++; $display("FAIL rr_grant[%0d] got found=%b g=%b id=%0d in=%b want g=%b id=%0d in=0", n, found, grant_onehot, stream_pe_id, stream_is_input, oh, exp_seq[n]); end
            repeat (3) tick();
            stream_complete = 1'b1;
            tick();
            stream_complete = 1'b0;
            checks++; if (stream_filter_finish !== oh) begin
                errors++; $display("FAIL rr_finish[%0d] got=%b want=%b", n, stream_filter_finish, oh); end
            req_filter_valid[exp_seq[n]] = 1'b0;
            tick();
            req_filter_valid[exp_seq[n]] = 1'b1;
        end
        req_filter_valid = 4'b0000;
        tick();
    endtask

    task automatic test_same_pe();
        bit found;
        req_input_valid  = 4'b0010;
        req_filter_valid = 4'b0010;
        wait_start(found);
        checks++; if (!found || grant_onehot !== 4'b0010 || stream_is_input !== 1'b1) begin
            errors++; $display("FAIL same_first got found=%b g=%b in=%b want 0010/1", found, grant_onehot, stream_is_input); end
        repeat (3) tick();
        stream_complete = 1'b1;
        tick();
        stream_complete = 1'b0;
        checks++; if (stream_input_finish !== 4'b0010 || stream_filter_finish !== 4'b0000) begin
            errors++; $display("FAIL same_in_finish got i=%b f=%b want 0010/0000", stream_input_finish, stream_filter_finish); end
        req_input_valid = 4'b0000;
        tick();
        wait_start(found);
        checks++; if (!found || grant_onehot !== 4'b0010 || stream_is_input !== 1'b0) begin
            errors++; $display("FAIL same_second got found=%b g=%b in=%b want 0010/0", found, grant_onehot, stream_is_input); end
        repeat (3) tick();
        stream_complete = 1'b1;
        tick();
        stream_complete = 1'b0;
        checks++; if (stream_filter_finish !== 4'b0010 || stream_input_finish !== 4'b0000) begin
            errors++; $display("FAIL same_f_finish got f=%b i=%b want 0010/0000", stream_filter_finish, stream_input_finish); end
        req_filter_valid = 4'b0000;
        tick();
    endtask

    task automatic test_held();
        bit found;
        req_filter_valid = 4'b0001;
        wait_start(found);
        checks++; if (!found || grant_onehot !== 4'b0001) begin
            errors++; $display("FAIL held_grant got found=%b g=%b want 0001", found, grant_onehot); end
        repeat (3) tick();
        stream_complete = 1'b1;
        tick();
        stream_complete = 1'b0;
        checks++; if (stream_filter_finish !== 4'b0001) begin
            errors++; $display("FAIL held_finish got=%b want=0001", stream_filter_finish); end
        tick();
        checks++; if (grant_onehot !== 4'b0000) begin
            errors++; $display("FAIL held_mask1 got g=%b want 0000", grant_onehot); end
        tick();
        checks++; if (grant_onehot !== 4'b0000 || stream_start !== 1'b0) begin
            errors++; $display("FAIL held_mask2 got g=%b st=%b want 0000/0", grant_onehot, stream_start); end
        req_filter_valid = 4'b0000;
        tick();
        req_filter_valid = 4'b0001;
        wait_start(found);
        checks++; if (!found || grant_onehot !== 4'b0001) begin
            errors++; $display("FAIL held_regrant got found=%b g=%b want 0001", found, grant_onehot); end
        repeat (3) tick();
        stream_complete = 1'b1;
        tick();
        stream_complete = 1'b0;
        req_filter_valid = 4'b0000;
        tick();
    endtask

    task automatic test_watchdog();
        bit found;
        int busy_cycles;
        int bad_finish;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL wd_pre got err_timeout=%b want 0", err_timeout); end
        req_input_valid = 4'b1000;
        wait_start(found);
        checks++; if (!found || grant_onehot !== 4'b1000 || stream_pe_id !== 2'd3) begin
            errors++; $display("FAIL wd_grant got found=%b g=%b id=%0d want 1000/3", found, grant_onehot, stream_pe_id); end
        busy_cycles = 0;
        bad_finish  = 0;
        while (grant_onehot != 4'b0000 && busy_cycles < 20) begin
            if (stream_input_finish != 4'b0 || stream_filter_finish != 4'b0) bad_finish++;
            tick();
            busy_cycles++;
        end
        checks++; if (busy_cycles != 8) begin errors++; $display("FAIL wd_busy_len got=%0d want=8", busy_cycles); end
        checks++; if (bad_finish != 0 || err_timeout !== 1'b1) begin
            errors++; $display("FAIL wd_abort got finish_pulses=%0d err_timeout=%b want 0/1", bad_finish, err_timeout); end
        wait_start(found);
        checks++; if (!found || grant_onehot !== 4'b1000 || stream_is_input !== 1'b1) begin
            errors++; $display("FAIL wd_retry got found=%b g=%b in=%b want 1000/1", found, grant_onehot, stream_is_input); end
        repeat (2) tick();
        stream_complete = 1'b1;
        tick();
        stream_complete = 1'b0;
        checks++; if (stream_input_finish !== 4'b1000) begin
            errors++; $display("FAIL wd_retry_finish got=%b want=1000", stream_input_finish); end
        req_input_valid = 4'b0000;
        tick();
    endtask

    task automatic test_spurious();
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL spur_pre got=%b want 0", err_spurious); end
        stream_complete = 1'b1;
        tick();
        stream_complete = 1'b0;
        tick();
        checks++; if (err_spurious !== 1'b1 || grant_onehot !== 4'b0000) begin
            errors++; $display("FAIL spur_flag got sp=%b g=%b want 1/0000", err_spurious, grant_onehot); end
    endtask

    task automatic test_reset_mid();
        bit found;
        req_filter_valid = 4'b0001;
        wait_start(found);
        checks++; if (!found || grant_onehot !== 4'b0001) begin
            errors++; $display("FAIL rstmid_grant got found=%b g=%b want 0001", found, grant_onehot); end
        tick();
        rst = 1'b1;
        stream_complete = 1'b1;
        tick();
        checks++; if (grant_onehot !== 4'b0 || stream_filter_finish !== 4'b0 || stream_input_finish !== 4'b0 || stream_start !== 1'b0) begin
            errors++; $display("FAIL rstmid_out got g=%b f=%b i=%b st=%b want all 0", grant_onehot, stream_filter_finish, stream_input_finish, stream_start); end
        checks++; if (err_timeout !== 1'b0 || err_spurious !== 1'b0) begin
            errors++; $display("FAIL rstmid_err got to=%b sp=%b want 0/0", err_timeout, err_spurious); end
        rst = 1'b0;
        stream_complete = 1'b0;
        req_filter_valid = 4'b0000;
        tick();
        checks++; if (err_spurious !== 1'b0 || stream_filter_finish !== 4'b0) begin
            errors++; $display("FAIL rstmid_after got sp=%b f=%b want 0/0000", err_spurious, stream_filter_finish); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_same_pe();
        test_held();
        test_watchdog();
        test_spurious();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
